// File: rtl/seg7_display_driver.sv
// Time-multiplexed common-anode 8-digit hex display driver for the CPUOut word.
// Optional feature: SEG7_LEADING_ZERO_BLANK_EN suppresses digits above the highest nonzero nibble.
module seg7_display_driver #(
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] CPUOut,
  output logic [6:0]  Seg,
  output logic        DP,
  output logic [7:0]  Anode
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {BLANK, DRIVE} state_t;

  logic [PW-1:0] prescaler;
  logic [2:0]    index;
  logic [31:0]   snapshot;
  state_t        state;
  logic          tick;
  logic          lastDigit;
  logic          inBlank;
  logic          digitOn;
  logic [3:0]    nibble;

  function automatic logic [6:0] hexSeg(input logic [3:0] v);
    case (v)
      4'h0: hexSeg = 7'h40;
      4'h1: hexSeg = 7'h79;
      4'h2: hexSeg = 7'h24;
      4'h3: hexSeg = 7'h30;
      4'h4: hexSeg = 7'h19;
      4'h5: hexSeg = 7'h12;
      4'h6: hexSeg = 7'h02;
      4'h7: hexSeg = 7'h78;
      4'h8: hexSeg = 7'h00;
      4'h9: hexSeg = 7'h10;
      4'hA: hexSeg = 7'h08;
      4'hB: hexSeg = 7'h03;
      4'hC: hexSeg = 7'h46;
      4'hD: hexSeg = 7'h21;
      4'hE: hexSeg = 7'h06;
      default: hexSeg = 7'h0E;
    endcase
  endfunction

  assign tick      = (prescaler == PW'(DIV - 1));
  assign lastDigit = (index == 3'(NUM_DIGITS - 1));
  assign nibble    = 4'(snapshot >> {index, 2'b00});

  // A zero-length blanking interval must not turn into a constant comparison.
  generate
    if (BLANK_CYCLES == 0) begin : gNoBlank
      assign inBlank = 1'b0;
    end else begin : gBlank
      assign inBlank = (prescaler < PW'(BLANK_CYCLES));
    end
  endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [2:0] hiDigit;

  function automatic logic [2:0] topNibble(input logic [31:0] v);
    topNibble = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (4'(v >> (4 * i)) != 4'h0) topNibble = 3'(i);
    end
  endfunction

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                              hiDigit <= '0;
    else if (prescaler == '0 && index == '0) hiDigit <= topNibble(CPUOut);
  end

  assign digitOn = (index <= hiDigit);
`else
  assign digitOn = 1'b1;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      prescaler <= '0;
      index     <= '0;
      snapshot  <= '0;
      state     <= BLANK;
      Seg       <= 7'h7F;
      DP        <= 1'b1;
      Anode     <= 8'hFF;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) index <= lastDigit ? '0 : index + 3'd1;
      if (prescaler == '0 && index == '0) snapshot <= CPUOut;
      DP <= 1'b1;
      // state records the phase that the outputs are presenting this cycle
      if (inBlank) begin
        state <= BLANK;
        Anode <= 8'hFF;
        Seg   <= 7'h7F;
      end else begin
        state <= DRIVE;
        if (digitOn) begin
          Anode <= ~(8'b1 << index);
          Seg   <= hexSeg(nibble);
        end else begin
          Anode <= 8'hFF;
          Seg   <= 7'h7F;
        end
      end
    end
  end

endmodule
